// File: rtl/aes_stream_adapter.sv
// Stream front-end for the AES core: packs four 32-bit words into a block, pulses ld,
// waits for done with a timeout, then streams the 128-bit result back as four words.
module aes_stream_adapter #(
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic         ld,
    output logic [127:0] key,
    output logic [127:0] text_in,
    input  logic         done,
    input  logic [127:0] text_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         err_timeout
);

    typedef enum logic [1:0] {FILL, LOAD, WAIT, DRAIN} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [7:0]   tmo_q, tmo_d;
    logic         in_ready_q, in_ready_d;
    logic         ld_q, ld_d;
    logic         out_valid_q, out_valid_d;
    logic         err_q, err_d;
    logic [127:0] key_q, key_d;
    logic [127:0] text_q, text_d;
    logic [127:0] buf_q, buf_d;

    logic in_hs;
    logic out_hs;
    logic last_word;

    assign in_hs     = in_valid && in_ready_q && (state_q == FILL);
    assign out_hs    = out_valid_q && out_ready && (state_q == DRAIN);
    assign last_word = (cnt_q == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= 2'd0;
            tmo_q       <= 8'd0;
            in_ready_q  <= 1'b0;
            ld_q        <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            key_q       <= '0;
            text_q      <= '0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            in_ready_q  <= in_ready_d;
            ld_q        <= ld_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            key_q       <= key_d;
            text_q      <= text_d;
            buf_q       <= buf_d;
        end
    end

    // done takes priority over the final timeout cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (in_hs && last_word) state_d = LOAD;
            LOAD:    state_d = WAIT;
            WAIT: begin
                if (done)                   state_d = DRAIN;
                else if (tmo_q == TMO_LAST) state_d = FILL;
            end
            DRAIN:   if (out_hs && last_word) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        in_ready_d  = in_ready_q;
        ld_d        = 1'b0;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        key_d       = key_q;
        text_d      = text_q;
        buf_d       = buf_q;
        case (state_q)
            FILL: begin
                in_ready_d = 1'b1;
                if (in_hs) begin
                    case (cnt_q)
                        2'd0: text_d[127:96] = in_data;
                        2'd1: text_d[95:64]  = in_data;
                        2'd2: text_d[63:32]  = in_data;
                        2'd3: text_d[31:0]   = in_data;
                    endcase
                    cnt_d = cnt_q + 2'd1;
                    if (last_word) begin
                        key_d      = key_in;
                        in_ready_d = 1'b0;
                        ld_d       = 1'b1;
                    end
                end
            end
            LOAD: begin
            end
            WAIT: begin
                if (done) begin
                    buf_d       = text_out;
                    out_valid_d = 1'b1;
                    tmo_d       = 8'd0;
                end else if (tmo_q == TMO_LAST) begin
                    err_d      = 1'b1;
                    tmo_d      = 8'd0;
                    in_ready_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            DRAIN: begin
                // the buffer shifts so the presented word always sits in the top slot
                if (out_hs) begin
                    buf_d = {buf_q[95:0], 32'h0};
                    cnt_d = cnt_q + 2'd1;
                    if (last_word) begin
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign in_ready    = in_ready_q;
    assign ld          = ld_q;
    assign key         = key_q;
    assign text_in     = text_q;
    assign out_valid   = out_valid_q;
    assign out_data    = buf_q[127:96];
    assign err_timeout = err_q;

endmodule

// File: tb/tb_aes_stream_adapter.sv
// Self-checking bench for aes_stream_adapter: a cycle-level behavioural model plus
// an emulated AES core, with directed FIPS-197 scenarios and randomized blocks.
module tb_aes_stream_adapter;

    localparam int TIMEOUT = 16;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    localparam int P_FILL  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_WAIT  = 2;
    localparam int P_DRAIN = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] key_in = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         ld;
    logic [127:0] key;
    logic [127:0] text_in;
    logic         done = 1'b0;
    logic [127:0] text_out = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;
    logic         err_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    aes_stream_adapter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .ld(ld), .key(key), .text_in(text_in), .done(done),
        .text_out(text_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [127:0] core_fn(input logic [127:0] t, input logic [127:0] k);
        logic [127:0] x;
        if (t == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        x = t ^ k;
        return {x[119:0], x[127:120]};
    endfunction

    // ---------------- emulated AES core (stimulus side) ----------------
    int           lat = 11;
    bit           core_en = 1'b1;
    bit           spur_req = 1'b0;
    bit           rand_spur = 1'b0;
    int           cd = 0;
    logic [127:0] c_text = '0;
    logic [127:0] c_key = '0;

    always @(negedge clk) begin
        bit fire;
        bit spur;
        fire = 1'b0;
        if (rst) begin
            cd = 0;
            done = 1'b0;
        end else begin
            if (ld && core_en) begin
                cd = lat;
                c_text = text_in;
                c_key = key;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) fire = 1'b1;
            end
            spur = spur_req || (rand_spur && cd == 0 && core_en && $urandom_range(0, 15) == 0);
            spur_req = 1'b0;
            done = fire || spur;
            text_out = fire ? core_fn(c_text, c_key) : {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // ---------------- cycle bookkeeping ----------------
    int cyc = 0;
    int ld_count = 0;
    int ld_cyc = 0;
    bit bg_rand = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (ld) begin
            ld_count++;
            ld_cyc = cyc;
        end
        if (bg_rand) out_ready = ($urandom_range(0, 1) == 1);
    end

    // ---------------- behavioural model ----------------
    int           m_phase = P_FILL;
    bit           m_ready = 1'b0;
    bit           m_ld = 1'b0;
    bit           m_valid = 1'b0;
    bit           m_err = 1'b0;
    logic [127:0] m_key = '0;
    logic [127:0] m_text = '0;
    int           m_wait = 0;
    logic [31:0]  m_words[$];
    logic [31:0]  m_outq[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = P_FILL; m_ready = 0; m_ld = 0; m_valid = 0; m_err = 0;
            m_key = '0; m_text = '0; m_wait = 0;
            m_words.delete(); m_outq.delete();
        end else begin
            case (m_phase)
                P_FILL: begin
                    m_ready = 1'b1;
                    if (in_valid && m_ready) begin
                        m_text[127 - 32*m_words.size() -: 32] = in_data;
                        m_words.push_back(in_data);
                        if (m_words.size() == 4) begin
                            m_key = key_in;
                            m_words.delete();
                            m_ready = 1'b0;
                            m_ld = 1'b1;
                            m_phase = P_LOAD;
                        end
                    end
                end
                P_LOAD: begin
                    m_ld = 1'b0;
                    m_wait = 0;
                    m_phase = P_WAIT;
                end
                P_WAIT: begin
                    m_wait++;
                    if (done) begin
                        for (int k = 0; k < 4; k++) m_outq.push_back(text_out[127 - 32*k -: 32]);
                        m_valid = 1'b1;
                        m_phase = P_DRAIN;
                    end else if (m_wait == TIMEOUT) begin
                        m_err = 1'b1;
                        m_ready = 1'b1;
                        m_phase = P_FILL;
                    end
                end
                default: begin
                    if (out_ready) begin
                        void'(m_outq.pop_front());
                        if (m_outq.size() == 0) begin
                            m_valid = 1'b0;
                            m_ready = 1'b1;
                            m_phase = P_FILL;
                        end
                    end
                end
            endcase
        end
    end

    // Every out-of-reset cycle: DUT outputs against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check_output("in_ready", in_ready, m_ready);
            check_output("ld", ld, m_ld);
            check_output("out_valid", out_valid, m_valid);
            check_output("err_timeout", err_timeout, m_err);
            check_output("key", key, m_key);
            check_output("text_in", text_in, m_text);
            if (m_valid && m_outq.size() > 0) check_output("out_data", out_data, m_outq[0]);
        end
    end

    // ---------------- stimulus tasks ----------------
    logic [31:0] got_q[$];

    task automatic apply_stimulus(input logic [127:0] blk, input logic [127:0] k,
                                  input int mode, input int spur_at);
        int i = 0;
        int guard = 0;
        int pidx = 0;
        bit v;
        bit spur_done = 1'b0;
        logic [6:0] pat = 7'b1001011;
        while (i < 4 && guard < 200) begin
            tick();
            guard++;
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = pat[6 - (pidx % 7)];
            else                v = ($urandom_range(0, 3) != 0);
            pidx++;
            if (i == spur_at && !spur_done) begin
                spur_req = 1'b1;
                spur_done = 1'b1;
            end
            in_valid = v;
            in_data  = blk[127 - 32*i -: 32];
            key_in   = (i == 3) ? k : {$urandom, $urandom, $urandom, $urandom};
            if (v && in_ready) i++;
        end
        tick();
        in_valid = 1'b0;
        if (i < 4) check_output("input_accept_timeout", 128'(i), 128'd4);
    endtask

    task automatic collect_output(input int stall_word);
        int n = 0;
        int guard = 0;
        int stall = 0;
        got_q.delete();
        while (n < 4 && guard < 200) begin
            tick();
            guard++;
            if (n == stall_word && stall < 3 && out_valid) begin
                out_ready = 1'b0;
                stall++;
                check_output("stall_hold_data", out_data, 32'hd8cdb780);
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                n++;
            end
        end
        tick();
        out_ready = 1'b0;
        if (n < 4) check_output("output_drain_timeout", 128'(n), 128'd4);
    endtask

    task automatic check_words(input string name, input logic [127:0] exp);
        logic [127:0] e;
        e = exp;
        for (int k = 0; k < 4; k++)
            check_output(name, (got_q.size() > k) ? got_q[k] : 32'hx, e[127 - 32*k -: 32]);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [127:0] blk;
        logic [127:0] k;
        int ld0;
        int g;

        // Reset values
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_output("rst_in_ready", in_ready, 1'b0);
        check_output("rst_ld", ld, 1'b0);
        check_output("rst_out_valid", out_valid, 1'b0);
        check_output("rst_out_data", out_data, 32'h0);
        check_output("rst_key", key, 128'h0);
        check_output("rst_text_in", text_in, 128'h0);
        check_output("rst_err", err_timeout, 1'b0);
        tick();
        check_output("in_ready_after_rst", in_ready, 1'b1);

        // FIPS-197 vector, core latency 11
        ld0 = ld_count;
        apply_stimulus(FIPS_PT, FIPS_KEY, 0, -1);
        check_output("fips_text_in", text_in, FIPS_PT);
        check_output("fips_key", key, FIPS_KEY);
        collect_output(4);
        check_words("fips_out", FIPS_CT);
        check_output("fips_in_ready_after", in_ready, 1'b1);
        check_output("fips_ld_pulses", 128'(ld_count - ld0), 128'd1);

        // Input gaps 1,0,0,1,0,1,1 and backpressure on word 2
        ld0 = ld_count;
        apply_stimulus(FIPS_PT, FIPS_KEY, 1, -1);
        check_output("gap_text_in", text_in, FIPS_PT);
        collect_output(2);
        check_words("bp_out", FIPS_CT);
        check_output("gap_ld_pulses", 128'(ld_count - ld0), 128'd1);

        // Spurious done while idle and mid-fill
        spur_req = 1'b1;
        repeat (3) tick();
        check_output("spur_out_valid", out_valid, 1'b0);
        check_output("spur_in_ready", in_ready, 1'b1);
        apply_stimulus(FIPS_PT, FIPS_KEY, 0, 2);
        check_output("spur_text_in", text_in, FIPS_PT);
        collect_output(4);
        check_words("spur_out", FIPS_CT);

        // Timeout: core never answers
        core_en = 1'b0;
        apply_stimulus(FIPS_PT, FIPS_KEY, 0, -1);
        g = 0;
        while (!err_timeout && g < 60) begin
            tick();
            g++;
        end
        check_output("tmo_err", err_timeout, 1'b1);
        check_output("tmo_cycles_after_ld", 128'(cyc - ld_cyc), 128'(TIMEOUT + 1));
        check_output("tmo_in_ready", in_ready, 1'b1);
        check_output("tmo_out_valid", out_valid, 1'b0);
        core_en = 1'b1;
        blk = {$urandom, $urandom, $urandom, $urandom};
        k   = {$urandom, $urandom, $urandom, $urandom};
        apply_stimulus(blk, k, 0, -1);
        collect_output(4);
        check_words("post_tmo_out", core_fn(blk, k));
        check_output("err_sticky", err_timeout, 1'b1);

        // Reset mid-DRAIN after word 1
        apply_stimulus(FIPS_PT, FIPS_KEY, 0, -1);
        g = 0;
        while (!out_valid && g < 40) begin
            tick();
            g++;
        end
        check_output("drain_reached", out_valid, 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check_output("midrst_out_valid", out_valid, 1'b0);
        check_output("midrst_err", err_timeout, 1'b0);
        check_output("midrst_in_ready", in_ready, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_output("midrst_in_ready_after", in_ready, 1'b1);

        // Fresh block where done lands on the last allowed WAIT cycle
        lat = TIMEOUT;
        apply_stimulus(FIPS_PT, FIPS_KEY, 0, -1);
        collect_output(4);
        check_words("edge_done_out", FIPS_CT);
        check_output("edge_done_no_err", err_timeout, 1'b0);

        // Randomized blocks, latencies across the timeout boundary, random backpressure
        bg_rand = 1'b1;
        rand_spur = 1'b1;
        for (int b = 0; b < 20; b++) begin
            lat = (b == 0) ? TIMEOUT + 1 : $urandom_range(1, TIMEOUT + 2);
            blk = {$urandom, $urandom, $urandom, $urandom};
            k   = {$urandom, $urandom, $urandom, $urandom};
            apply_stimulus(blk, k, 2, -1);
            g = 0;
            while (m_phase != P_FILL && g < 100) begin
                tick();
                g++;
            end
            if (g >= 100) check_output("random_block_timeout", 128'(g), 128'd0);
        end
        bg_rand = 1'b0;
        rand_spur = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
